// File: rtl/int_arbiter_pkg.sv
// int_arbiter_pkg
//   Shared definitions for the external interrupt arbiter: register
//   offsets (decoded from addr[3:2]), the "no source" id value and the
//   arbiter FSM state encoding.
package int_arbiter_pkg;

    // Register selects, compared against addr[3:2]
    localparam logic [1:0] INT_ARB_ENABLE  = 2'd0;
    localparam logic [1:0] INT_ARB_PENDING = 2'd1;
    localparam logic [1:0] INT_ARB_TRIGGER = 2'd2;
    localparam logic [1:0] INT_ARB_CLAIM   = 2'd3;

    // Source ids start at 1; id 0 means no source
    localparam int ID_NONE = 0;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_SERVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/int_sync.sv
// int_sync
//   Two-flop synchronizer for a vector of asynchronous lines, followed by a
//   registered copy of the synchronized value for rising-edge detection.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset
//   d     in   [WIDTH] raw asynchronous lines
//   s     out  [WIDTH] synchronized lines
//   rise  out  [WIDTH] one-cycle pulse where s went 0 -> 1
module int_sync
    import int_arbiter_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] s_d;

    // meta -> s is the metastability chain; s_d is only for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            s    <= '0;
            s_d  <= '0;
        end else begin
            meta <= d;
            s    <= meta;
            s_d  <= s;
        end
    end

    assign rise = s & ~s_d;

endmodule

// File: rtl/int_arbiter.sv
// int_arbiter
//   External interrupt arbiter. Synchronizes N_SRC interrupt lines, keeps a
//   pending vector (edge or level per source), masks with ENABLE and picks
//   the lowest-index candidate. One source is served at a time through a
//   claim (read CLAIM) / complete (write CLAIM with the id) handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   irq_i        [N_SRC] raw interrupt lines, active-high
//   we_i, re_i   bus write / read strobes
//   addr_i       [4] byte offset, [3:2] selects ENABLE/PENDING/TRIGGER/CLAIM
//   wdata_i      [32] bus write data
//   rdata_o      [32] combinational read data for addr_i
//   ext_irq_o    registered interrupt request toward the core
//   claim_id_o   [ID_W] id currently in service, 0 when idle
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [3:0]       addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             ext_irq_o,
    output logic [ID_W-1:0]  claim_id_o
);

    logic [N_SRC-1:0] enable_q;
    logic [N_SRC-1:0] trigger_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] sync_s;
    logic [N_SRC-1:0] sync_rise;
    logic [N_SRC-1:0] in_service;
    logic [N_SRC-1:0] candidates;
    logic [N_SRC-1:0] winner_oh;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] claim_clr;
    logic [ID_W-1:0]  winner_id;
    logic [ID_W-1:0]  claim_id_q;
    logic [ID_W-1:0]  claim_id_d;
    logic [1:0]       reg_sel;
    logic             claim_rd;
    logic             claim_wr;
    logic             claim_take;
    logic             found;
    logic             unused_bits;
    arb_state_t       state_q;
    arb_state_t       state_d;

    int_sync #(
        .WIDTH(N_SRC)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (irq_i),
        .s    (sync_s),
        .rise (sync_rise)
    );

    assign reg_sel     = addr_i[3:2];
    assign claim_rd    = re_i && (reg_sel == INT_ARB_CLAIM);
    assign claim_wr    = we_i && (reg_sel == INT_ARB_CLAIM);
    assign unused_bits = &{1'b0, addr_i[1:0], wdata_i[31:N_SRC]};

    // The source in service is excluded from arbitration until completed
    always_comb begin
        in_service = '0;
        for (int i = 0; i < N_SRC; i++) begin
            in_service[i] = (state_q == ARB_SERVE) && (claim_id_q == ID_W'(i + 1));
        end
    end

    assign candidates = pending_q & enable_q & ~in_service;

    // Fixed priority: the first candidate found from index 0 upward wins
    always_comb begin
        winner_oh = '0;
        winner_id = ID_W'(ID_NONE);
        found     = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (candidates[i] && !found) begin
                found        = 1'b1;
                winner_oh[i] = 1'b1;
                winner_id    = ID_W'(i + 1);
            end
        end
    end

    // Claim/complete FSM: a claim read captures the winner, a matching
    // complete write releases it; anything else leaves the state alone
    always_comb begin
        state_d    = state_q;
        claim_id_d = claim_id_q;
        claim_take = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (claim_rd && (winner_id != ID_W'(ID_NONE))) begin
                    state_d    = ARB_SERVE;
                    claim_id_d = winner_id;
                    claim_take = 1'b1;
                end
            end
            ARB_SERVE: begin
                if (claim_wr && (wdata_i[ID_W-1:0] == claim_id_q)) begin
                    state_d    = ARB_IDLE;
                    claim_id_d = ID_W'(ID_NONE);
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                claim_id_d = ID_W'(ID_NONE);
            end
        endcase
    end

    // Edge bits: clear by W1C or claim, but a new rise in the same cycle
    // keeps the bit set. Level bits simply follow the synchronized line.
    assign w1c       = (we_i && (reg_sel == INT_ARB_PENDING)) ? wdata_i[N_SRC-1:0] : '0;
    assign claim_clr = claim_take ? winner_oh : '0;
    assign pending_d = (trigger_q & ((pending_q & ~(w1c | claim_clr)) | sync_rise))
                     | (~trigger_q & sync_s);

    // Register file, pending vector, FSM state and the request flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= '0;
            trigger_q  <= '0;
            pending_q  <= '0;
            state_q    <= ARB_IDLE;
            claim_id_q <= ID_W'(ID_NONE);
            ext_irq_o  <= 1'b0;
        end else begin
            if (we_i && (reg_sel == INT_ARB_ENABLE)) begin
                enable_q <= wdata_i[N_SRC-1:0];
            end
            if (we_i && (reg_sel == INT_ARB_TRIGGER)) begin
                trigger_q <= wdata_i[N_SRC-1:0];
            end
            pending_q  <= pending_d;
            state_q    <= state_d;
            claim_id_q <= claim_id_d;
            ext_irq_o  <= (state_q == ARB_IDLE) && (|candidates);
        end
    end

    assign claim_id_o = claim_id_q;

    // Read mux; the claim register shows 0 while a source is in service
    always_comb begin
        rdata_o = '0;
        case (reg_sel)
            INT_ARB_ENABLE:  rdata_o[N_SRC-1:0] = enable_q;
            INT_ARB_PENDING: rdata_o[N_SRC-1:0] = pending_q;
            INT_ARB_TRIGGER: rdata_o[N_SRC-1:0] = trigger_q;
            default: begin
                if (state_q == ARB_IDLE) begin
                    rdata_o[ID_W-1:0] = winner_id;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter
//   Scoreboard bench for int_arbiter. Each driven cycle pushes expected
//   values (read data, ext_irq_o, claim_id_o) from a reference model; a
//   monitor on the falling edge pops and compares them.
module tb_int_arbiter;

    localparam logic [3:0] A_EN    = 4'h0;
    localparam logic [3:0] A_PEND  = 4'h4;
    localparam logic [3:0] A_TRIG  = 4'h8;
    localparam logic [3:0] A_CLAIM = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_i;
    logic        we_i;
    logic        re_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ext_irq_o;
    logic [4:0]  claim_id_o;

    int_arbiter #(
        .N_SRC(8),
        .ID_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_i     (irq_i),
        .we_i      (we_i),
        .re_i      (re_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .ext_irq_o (ext_irq_o),
        .claim_id_o(claim_id_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          done = 1'b0;
    exp_t        e;
    logic [31:0] act;

    // Reference model: register contents as plain bit vectors, served id
    // as an integer, and a sample history of the raw lines (newest first)
    bit [7:0] m_en;
    bit [7:0] m_trig;
    bit [7:0] m_pend;
    int       m_serv;
    bit       m_ext;
    bit [7:0] m_hist[$];
    bit [7:0] irq_cur;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation tagged for the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            case (e.sel)
                0:       act = rdata_o;
                1:       act = {31'b0, ext_irq_o};
                default: act = {27'b0, claim_id_o};
            endcase
            if (e.cyc != cyc) begin
                errors++;
                $display("[TB] FAIL %s: not sampled in cycle %0d, expected 0x%0h", e.name, e.cyc, e.val);
            end else if (act !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
        if (done) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL %s: never sampled, expected 0x%0h", e.name, e.val);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void pushExp(int sel, logic [31:0] val, string name);
        exp_t x;
        x.cyc  = cyc;
        x.sel  = sel;
        x.val  = val;
        x.name = name;
        sb.push_back(x);
    endfunction

    task automatic modelReset();
        m_en   = '0;
        m_trig = '0;
        m_pend = '0;
        m_serv = 0;
        m_ext  = 1'b0;
        m_hist.delete();
        repeat (3) m_hist.push_back(8'h00);
    endtask

    // Highest priority = lowest index among enabled pending sources,
    // skipping the one being served
    function automatic int modelWinner();
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && m_en[i] && (i + 1 != m_serv)) return i + 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] modelRead(logic [3:0] a);
        case (a[3:2])
            2'd0:    return {24'b0, m_en};
            2'd1:    return {24'b0, m_pend};
            2'd2:    return {24'b0, m_trig};
            default: return (m_serv == 0) ? 32'(modelWinner()) : 32'd0;
        endcase
    endfunction

    // One clock edge of the model, using the inputs driven this cycle
    task automatic modelStep();
        bit [7:0] s, rise, clr, pnew;
        int       win, nserv;
        s     = m_hist[1];
        rise  = m_hist[1] & ~m_hist[2];
        win   = modelWinner();
        nserv = m_serv;
        clr   = '0;
        if (we_i && addr_i[3:2] == 2'd1) clr = wdata_i[7:0];
        if (re_i && addr_i[3:2] == 2'd3 && m_serv == 0 && win != 0) begin
            nserv = win;
            clr   = clr | 8'(1 << (win - 1));
        end
        if (we_i && addr_i[3:2] == 2'd3 && m_serv != 0 && int'(wdata_i[4:0]) == m_serv) nserv = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_trig[i]) pnew[i] = (m_pend[i] && !clr[i]) || rise[i];
            else           pnew[i] = s[i];
        end
        m_ext = (m_serv == 0) && (win != 0);
        if (we_i && addr_i[3:2] == 2'd0) m_en   = wdata_i[7:0];
        if (we_i && addr_i[3:2] == 2'd2) m_trig = wdata_i[7:0];
        m_pend = pnew;
        m_serv = nserv;
        m_hist.push_front(irq_i);
        void'(m_hist.pop_back());
    endtask

    // Drive one cycle's inputs and queue the model's expectations for it
    task automatic applyStimulus(logic w, logic r, logic [3:0] a, logic [31:0] d, logic [7:0] irq);
        we_i    = w;
        re_i    = r;
        addr_i  = a;
        wdata_i = d;
        irq_i   = irq;
        if (r) pushExp(0, modelRead(a), $sformatf("read_%0h", a));
        pushExp(1, {31'b0, m_ext}, "ext_irq_o");
        pushExp(2, 32'(m_serv), "claim_id_o");
    endtask

    // Extra fixed expectation for the current cycle
    task automatic checkOutput(string name, int sel, logic [31:0] val);
        pushExp(sel, val, name);
    endtask

    task automatic tick();
        if (!rst_n) modelReset();
        else        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(int n, logic [7:0] irq);
        repeat (n) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, irq);
            tick();
        end
    endtask

    task automatic writeReg(logic [3:0] a, logic [31:0] d, logic [7:0] irq);
        applyStimulus(1'b1, 1'b0, a, d, irq);
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        irq_i   = '0;
        we_i    = 1'b0;
        re_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        irq_cur = '0;
        modelReset();
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1'b0, 1'b1, A_EN, 32'h0, 8'h00);
        checkOutput("rst_enable", 0, 32'h0);
        checkOutput("rst_ext", 1, 32'h0);
        checkOutput("rst_claim_id", 2, 32'h0);
        tick();
        rst_n = 1'b1;
        idleCycles(2, 8'h00);

        // Single edge on source 3
        writeReg(A_TRIG, 32'hFF, 8'h00);
        writeReg(A_EN, 32'h04, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h04);
        tick();
        idleCycles(2, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h00);
        checkOutput("edge_ext_early", 1, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h00);
        checkOutput("edge_ext_rise", 1, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h00);
        checkOutput("edge_claim", 0, 32'd3);
        tick();
        applyStimulus(1'b0, 1'b1, A_PEND, 32'h0, 8'h00);
        checkOutput("edge_pend_cleared", 0, 32'h0);
        checkOutput("edge_claim_id", 2, 32'd3);
        tick();
        writeReg(A_CLAIM, 32'd3, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h00);
        checkOutput("edge_done_id", 2, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h00);
        checkOutput("edge_done_ext", 1, 32'h0);
        tick();

        // Priority between sources 2 and 6
        writeReg(A_EN, 32'h22, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h22);
        tick();
        idleCycles(5, 8'h00);
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h00);
        checkOutput("prio_first", 0, 32'd2);
        tick();
        idleCycles(1, 8'h00);
        writeReg(A_CLAIM, 32'd2, 8'h00);
        idleCycles(2, 8'h00);
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h00);
        checkOutput("prio_second", 0, 32'd6);
        tick();
        writeReg(A_CLAIM, 32'd6, 8'h00);
        idleCycles(2, 8'h00);
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h00);
        checkOutput("prio_none", 0, 32'd0);
        tick();

        // Level source 1 held high
        writeReg(A_TRIG, 32'h00, 8'h00);
        writeReg(A_EN, 32'h01, 8'h00);
        idleCycles(5, 8'h01);
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h01);
        checkOutput("level_claim", 0, 32'd1);
        tick();
        writeReg(A_CLAIM, 32'd1, 8'h01);
        idleCycles(1, 8'h01);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h01);
        checkOutput("level_reassert", 1, 32'h1);
        tick();
        idleCycles(4, 8'h00);
        applyStimulus(1'b0, 1'b1, A_PEND, 32'h0, 8'h00);
        checkOutput("level_dropped", 0, 32'h0);
        tick();

        // Masking and mismatched complete
        writeReg(A_TRIG, 32'hFF, 8'h00);
        writeReg(A_EN, 32'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h80);
        tick();
        idleCycles(5, 8'h00);
        applyStimulus(1'b0, 1'b1, A_PEND, 32'h0, 8'h00);
        checkOutput("mask_pending", 0, 32'h80);
        checkOutput("mask_no_ext", 1, 32'h0);
        tick();
        writeReg(A_EN, 32'h04, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h04);
        tick();
        idleCycles(5, 8'h00);
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h00);
        checkOutput("mask_claim", 0, 32'd3);
        tick();
        writeReg(A_CLAIM, 32'd4, 8'h00);
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h00);
        checkOutput("mismatch_kept", 2, 32'd3);
        checkOutput("serve_claim_zero", 0, 32'd0);
        tick();
        writeReg(A_CLAIM, 32'd3, 8'h00);
        writeReg(A_PEND, 32'h80, 8'h00);
        idleCycles(2, 8'h00);

        // Set in the same cycle as a W1C of source 2
        writeReg(A_EN, 32'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h02);
        tick();
        idleCycles(4, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h02);
        tick();
        idleCycles(1, 8'h00);
        writeReg(A_PEND, 32'h02, 8'h00);
        applyStimulus(1'b0, 1'b1, A_PEND, 32'h0, 8'h00);
        checkOutput("race_set_wins", 0, 32'h02);
        tick();
        writeReg(A_PEND, 32'h02, 8'h00);
        applyStimulus(1'b0, 1'b1, A_PEND, 32'h0, 8'h00);
        checkOutput("w1c_clears", 0, 32'h00);
        tick();

        // Reset while serving
        writeReg(A_EN, 32'h04, 8'h00);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h04);
        tick();
        idleCycles(5, 8'h00);
        applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h00);
        checkOutput("pre_reset_serving", 2, 32'd3);
        tick();
        rst_n = 1'b0;
        modelReset();
        applyStimulus(1'b0, 1'b1, A_EN, 32'h0, 8'h00);
        checkOutput("mid_rst_enable", 0, 32'h0);
        checkOutput("mid_rst_id", 2, 32'h0);
        checkOutput("mid_rst_ext", 1, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, A_PEND, 32'h0, 8'h00);
        checkOutput("mid_rst_pending", 0, 32'h0);
        tick();
        rst_n = 1'b1;
        idleCycles(2, 8'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int op;
            irq_cur = irq_cur ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            op = $urandom_range(0, 11);
            case (op)
                0:       applyStimulus(1'b1, 1'b0, A_EN, $urandom, irq_cur);
                1:       applyStimulus(1'b1, 1'b0, A_TRIG, $urandom, irq_cur);
                2:       applyStimulus(1'b1, 1'b0, A_PEND, $urandom, irq_cur);
                3, 4, 5: applyStimulus(1'b0, 1'b1, A_CLAIM, 32'h0, irq_cur);
                6, 7:    applyStimulus(1'b1, 1'b0, A_CLAIM, (m_serv != 0) ? 32'(m_serv) : 32'($urandom_range(0, 9)), irq_cur);
                8:       applyStimulus(1'b1, 1'b0, A_CLAIM, 32'($urandom_range(0, 9)), irq_cur);
                9:       applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)), 32'h0, irq_cur);
                default: applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, irq_cur);
            endcase
            tick();
        end

        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 8'h00);
        done = 1'b1;
    end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

External interrupt arbiter feeding the core's interrupt controller. Synchronizes up to N_SRC asynchronous peripheral interrupt lines, latches them as pending (edge or level per source), applies a per-source enable mask, and selects the highest-priority pending source using fixed priority. It raises a single request toward the core and serves one interrupt at a time through a memory-mapped claim/complete handshake on the peripheral bus.

## Interface
Parameters:
- N_SRC, 8: number of interrupt sources (1..31); source id = index + 1, id 0 means "none".
- ID_W, 5: width of source id fields.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- irq_i  in  N_SRC  raw asynchronous interrupt lines, active-high.
- we_i  in  1  bus write strobe.
- re_i  in  1  bus read strobe.
- addr_i  in  4  byte offset; only [3:2] is decoded.
- wdata_i  in  32  bus write data.
- rdata_o  out  32  bus read data, combinational from addr_i.
- ext_irq_o  out  1  registered interrupt request to core.
- claim_id_o  out  ID_W  id currently in service, 0 when idle.

## Operation
- Registers, by addr_i[3:2]:
  - 0 ENABLE, RW, reset 0.
  - 1 PENDING: read returns the pending vector. Write-1-clears edge-type bits; level-type bits ignore the write.
  - 2 TRIGGER, RW, reset 0: 1=edge, 0=level.
  - 3 CLAIM: a read returns the winning id, or 0 if none. A write is a complete.
- Unused upper bits read 0. Writes to unmapped bits are ignored.
- Synchronizer: two flops per line; sync value s. Edge detect compares s with its registered copy s_d.
- Pending, edge sources: set on rising s & ~s_d. Cleared by claim of that source or by PENDING W1C. A set in the same cycle as a clear wins.
- Pending, level sources: pending mirrors s every cycle.
- Candidates: pending & ENABLE, with the in-service source masked. The lowest index wins (source 0 has the highest priority).
- FSM:
  - IDLE: re_i & CLAIM & winner≠0 → SERVE. Capture claim_id = winner; clear the winner's pending if it is edge-type.
  - IDLE: a claim read with no winner returns 0 and stays in IDLE.
  - SERVE: we_i & CLAIM & wdata_i[ID_W-1:0]==claim_id → IDLE, claim_id←0.
  - SERVE: a mismatching complete is ignored.
  - SERVE: a claim read returns 0 with no state change (non-preemptive; one source in service).
- ext_irq_o: registered; high when state==IDLE and any candidate exists.
- Changing ENABLE or TRIGGER takes effect in the next cycle's arbitration. A source disabled while in service stays in service until complete.

## Timing
- Reset values: all registers, sync flops, pending, state=IDLE, claim_id_o=0, ext_irq_o=0.
- Latency: irq_i high before edge k gives s=1 after edge k+1, pending=1 after edge k+2, ext_irq_o=1 after edge k+3.
- Claim: a read at edge c moves the state to SERVE at c. ext_irq_o drops after edge c+1.
- Complete: a write at edge d returns the state to IDLE. If another candidate exists, ext_irq_o rises after edge d+1.
- rdata_o is valid in the same cycle as re_i. Side effects (claim) happen at the closing clock edge.
- A same-cycle re_i and we_i to CLAIM is a protocol error and has no defined effect. Verification must not drive it.
- Asserting rst_n low mid-SERVE returns the block to IDLE asynchronously and clears all pending bits.

## Structure
- Shared package/defines holds:
  - register offsets INT_ARB_ENABLE/PENDING/TRIGGER/CLAIM;
  - the ID_NONE=0 constant;
  - FSM encodings ARB_IDLE and ARB_SERVE.
- Sub-module int_sync: per-line 2-flop synchronizer plus edge detect, outputs s and rise. Instantiated once with vector width N_SRC.
- Top level holds the register file, pending logic, priority encoder (loop, lowest index first) and FSM.

## Test plan
- Single edge: TRIGGER=0xFF, ENABLE=0x04, pulse irq_i[2] for 1 cycle → ext_irq_o high 3 edges later. CLAIM read=3. PENDING=0. Complete write 3 → claim_id_o=0, ext_irq_o stays 0.
- Priority: edge sources 1 and 5 fire simultaneously with both enabled → first claim=2. Complete → second claim=6. Then claim=0.
- Level hold: TRIGGER=0, irq_i[0] held high → claim=1. Complete while still high → ext_irq_o reasserts. Drop irq_i → pending clears after 2 cycles.
- Masking/mismatch: a pending but disabled source gives no ext_irq_o. While in SERVE with id 3, complete 4 → ignored; claim read returns 0.
- Set-vs-clear race: an edge on source 2 coinciding with a PENDING W1C of bit 2 → pending stays 1.
- Reset mid-SERVE: assert rst_n low → claim_id_o=0, ext_irq_o=0, PENDING=0, ENABLE=0 immediately.
